reorder_buffer: RTL and testbench

- 16-entry circular reorder buffer (ROB) that sits directly upstream of the architectural register file.
- Allocates one tag per cycle, in program order, to dispatched instructions.
- Captures results from two writeback (CDB) ports.
- Retires up to 3 completed entries per cycle, in order, onto the register file's retirement write ports ({value[15:0], dest[3:0]} plus enable).
- ROB tag (4 bits) is the "owner" value held in the register file.

---
 rtl/rob_pkg.sv | 29 ++
 rtl/rob_retire_select.sv | 32 +++
 rtl/reorder_buffer.sv | 119 +++++++++++
 tb/tb_reorder_buffer.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared constants and types for the 16-entry reorder buffer.
package rob_pkg;

    localparam int TAG_W  = 4;
    localparam int DATA_W = 16;
    localparam int REG_W  = 4;
    localparam int RET_W  = 3;
    localparam int CDB_N  = 2;
    localparam int DEPTH  = 2 ** TAG_W;

    typedef logic [TAG_W-1:0] rob_tag_t;

    // Number of entries retired in one cycle, 0..RET_W
    typedef logic [1:0] ret_cnt_t;

    // Retirement word as seen by the register file: {value, dest}
    typedef struct packed {
        logic [DATA_W-1:0] value;
        logic [REG_W-1:0]  dest;
    } ret_word_t;

    typedef struct packed {
        logic              valid;
        logic              done;
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] value;
    } rob_entry_t;

endpackage

// File: rtl/rob_retire_select.sv
// Counts how many consecutive entries starting at head are valid and done
// (at most three); purely combinational from registered state.
module rob_retire_select
    import rob_pkg::*;
(
    input  logic [DEPTH-1:0] valid,
    input  logic [DEPTH-1:0] done,
    input  rob_tag_t         head,
    output ret_cnt_t         n
);

    logic [RET_W-1:0] ready;

    // Ready flags for head, head+1, head+2 (indices wrap mod DEPTH), then prefix length
    always_comb begin
        ready = '0;
        for (int i = 0; i < RET_W; i++) begin
            ready[i] = valid[head + rob_tag_t'(i)] && done[head + rob_tag_t'(i)];
        end
        n = 2'd0;
        if (ready[0]) begin
            n = 2'd1;
            if (ready[1]) begin
                n = 2'd2;
                if (ready[2]) begin
                    n = 2'd3;
                end
            end
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// 16-entry circular reorder buffer: in-order allocation, two writeback ports,
// in-order retirement of up to three entries per cycle.
// Optional: define ROB_FLUSH_EN to add a flush input that empties the buffer.
module reorder_buffer
    import rob_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
`ifdef ROB_FLUSH_EN
    input  logic                      flush,
`endif
    input  logic                      alloc_valid,
    input  logic [REG_W-1:0]          alloc_dest,
    output logic                      alloc_ready,
    output logic [TAG_W-1:0]          alloc_tag,
    input  logic                      cdb_valid [0:CDB_N-1],
    input  logic [TAG_W-1:0]          cdb_tag   [0:CDB_N-1],
    input  logic [DATA_W-1:0]         cdb_value [0:CDB_N-1],
    output logic [DATA_W+REG_W-1:0]   retirement_write_data        [0:RET_W-1],
    output logic                      retirement_write_data_enable [0:RET_W-1],
    output logic [TAG_W:0]            occupancy
);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] done_q;
    ret_word_t        word_q [DEPTH];
    rob_tag_t         head;
    rob_tag_t         tail;
    logic [TAG_W:0]   count;

    rob_tag_t         ret_idx [RET_W];
    ret_cnt_t         ret_n;
    logic [CDB_N-1:0] cdb_ok;
    logic             alloc_fire;
    logic             clear;

    // Reset and flush have the same effect on state, so one clear term covers both
`ifdef ROB_FLUSH_EN
    assign clear = rst || flush;
`else
    assign clear = rst;
`endif

    assign alloc_ready = (count < (TAG_W+1)'(DEPTH));
    assign alloc_tag   = tail;
    assign occupancy   = count;
    assign alloc_fire  = alloc_valid && alloc_ready;

    rob_retire_select u_select (
        .valid (valid_q),
        .done  (done_q),
        .head  (head),
        .n     (ret_n)
    );

    // Retirement indices and writeback acceptance (only pending, not-yet-done entries)
    always_comb begin
        for (int i = 0; i < RET_W; i++) begin
            ret_idx[i] = head + rob_tag_t'(i);
        end
        cdb_ok = '0;
        for (int k = 0; k < CDB_N; k++) begin
            cdb_ok[k] = cdb_valid[k] && valid_q[cdb_tag[k]] && !done_q[cdb_tag[k]];
        end
    end

    // Control state: entry flags, pointers, count and registered retirement ports
    always_ff @(posedge clk) begin
        if (clear) begin
            valid_q <= '0;
            done_q  <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            for (int i = 0; i < RET_W; i++) begin
                retirement_write_data_enable[i] <= 1'b0;
                retirement_write_data[i]        <= '0;
            end
        end else begin
            for (int i = 0; i < RET_W; i++) begin
                if (i < int'(ret_n)) begin
                    retirement_write_data_enable[i] <= 1'b1;
                    retirement_write_data[i]        <= word_q[ret_idx[i]];
                    valid_q[ret_idx[i]]             <= 1'b0;
                    done_q[ret_idx[i]]              <= 1'b0;
                end else begin
                    retirement_write_data_enable[i] <= 1'b0;
                    retirement_write_data[i]        <= '0;
                end
            end
            // Allocation only happens below full, so tail never aliases a retiring entry
            if (alloc_fire) begin
                valid_q[tail] <= 1'b1;
                done_q[tail]  <= 1'b0;
            end
            for (int k = 0; k < CDB_N; k++) begin
                if (cdb_ok[k]) begin
                    done_q[cdb_tag[k]] <= 1'b1;
                end
            end
            head  <= head + rob_tag_t'(ret_n);
            tail  <= tail + rob_tag_t'(alloc_fire);
            count <= count + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(ret_n);
        end
    end

    // Entry payload: dest on allocation, value on writeback; later port wins on a shared tag
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            word_q[tail].dest <= alloc_dest;
        end
        for (int k = 0; k < CDB_N; k++) begin
            if (cdb_ok[k]) begin
                word_q[cdb_tag[k]].value <= cdb_value[k];
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst;
`ifdef ROB_FLUSH_EN
    logic        flush;
`endif
    logic        alloc_valid;
    logic [3:0]  alloc_dest;
    logic        alloc_ready;
    logic [3:0]  alloc_tag;
    logic        cv   [0:1];
    logic [3:0]  ct   [0:1];
    logic [15:0] cval [0:1];
    logic [19:0] rdata [0:2];
    logic        ren   [0:2];
    logic [4:0]  occupancy;

    int errors = 0;
    int checks = 0;

    reorder_buffer dut (
        .clk                          (clk),
        .rst                          (rst),
`ifdef ROB_FLUSH_EN
        .flush                        (flush),
`endif
        .alloc_valid                  (alloc_valid),
        .alloc_dest                   (alloc_dest),
        .alloc_ready                  (alloc_ready),
        .alloc_tag                    (alloc_tag),
        .cdb_valid                    (cv),
        .cdb_tag                      (ct),
        .cdb_value                    (cval),
        .retirement_write_data        (rdata),
        .retirement_write_data_enable (ren),
        .occupancy                    (occupancy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cdb_idle();
        cv[0] = 1'b0; cv[1] = 1'b0;
        ct[0] = '0;   ct[1] = '0;
        cval[0] = '0; cval[1] = '0;
    endtask

    task automatic cdb_set(input int k, input logic [3:0] tag, input logic [15:0] value);
        cv[k] = 1'b1; ct[k] = tag; cval[k] = value;
    endtask

    task automatic alloc_n(input int n, input logic [3:0] first_dest);
        alloc_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            alloc_dest = first_dest + 4'(i);
            tick();
        end
        alloc_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", alloc_ready); end
        checks++;
        if (alloc_tag !== 4'd0) begin errors++; $display("FAIL reset_tag got=%0d want=0", alloc_tag); end
        checks++;
        if (occupancy !== 5'd0) begin errors++; $display("FAIL reset_occ got=%0d want=0", occupancy); end
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (ren[s] !== 1'b0 || rdata[s] !== 20'h0) begin
                errors++; $display("FAIL reset_slot%0d got en=%b data=%h want en=0 data=00000", s, ren[s], rdata[s]);
            end
        end
    endtask

    task automatic test_in_order();
        logic        exp_en [3];
        logic [19:0] exp_d  [3];
        alloc_n(3, 4'd1);
        checks++;
        if (occupancy !== 5'd3 || alloc_tag !== 4'd3) begin
            errors++; $display("FAIL inorder_alloc got occ=%0d tag=%0d want occ=3 tag=3", occupancy, alloc_tag);
        end
        cdb_set(0, 4'd0, 16'h00AA);
        cdb_set(1, 4'd1, 16'h00BB);
        tick();
        checks++;
        if (ren[0] !== 1'b0 || ren[1] !== 1'b0 || ren[2] !== 1'b0) begin
            errors++; $display("FAIL inorder_latency got en=%b%b%b want 000", ren[0], ren[1], ren[2]);
        end
        cdb_idle();
        cdb_set(0, 4'd2, 16'h00CC);
        tick();
        cdb_idle();
        exp_en = '{1'b1, 1'b1, 1'b0};
        exp_d  = '{20'h00AA1, 20'h00BB2, 20'h0};
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (ren[s] !== exp_en[s] || rdata[s] !== exp_d[s]) begin
                errors++; $display("FAIL inorder_first_slot%0d got en=%b data=%h want en=%b data=%h", s, ren[s], rdata[s], exp_en[s], exp_d[s]);
            end
        end
        checks++;
        if (occupancy !== 5'd1) begin errors++; $display("FAIL inorder_occ1 got=%0d want=1", occupancy); end
        tick();
        exp_en = '{1'b1, 1'b0, 1'b0};
        exp_d  = '{20'h00CC3, 20'h0, 20'h0};
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (ren[s] !== exp_en[s] || rdata[s] !== exp_d[s]) begin
                errors++; $display("FAIL inorder_second_slot%0d got en=%b data=%h want en=%b data=%h", s, ren[s], rdata[s], exp_en[s], exp_d[s]);
            end
        end
        tick();
        checks++;
        if (ren[0] !== 1'b0 || occupancy !== 5'd0) begin
            errors++; $display("FAIL inorder_empty got en0=%b occ=%0d want en0=0 occ=0", ren[0], occupancy);
        end
    endtask

    task automatic test_out_of_order();
        logic        exp_en [3];
        logic [19:0] exp_d  [3];
        alloc_n(3, 4'd4);
        cdb_set(0, 4'd5, 16'h0555);
        tick();
        cdb_idle();
        tick();
        checks++;
        if (ren[0] !== 1'b0 || ren[1] !== 1'b0 || ren[2] !== 1'b0) begin
            errors++; $display("FAIL ooo_blocked got en=%b%b%b want 000", ren[0], ren[1], ren[2]);
        end
        cdb_set(0, 4'd4, 16'h0444);
        cdb_set(1, 4'd3, 16'h0333);
        tick();
        cdb_idle();
        checks++;
        if (ren[0] !== 1'b0) begin errors++; $display("FAIL ooo_latency got en0=%b want 0", ren[0]); end
        tick();
        exp_en = '{1'b1, 1'b1, 1'b1};
        exp_d  = '{20'h03334, 20'h04445, 20'h05556};
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (ren[s] !== exp_en[s] || rdata[s] !== exp_d[s]) begin
                errors++; $display("FAIL ooo_slot%0d got en=%b data=%h want en=%b data=%h", s, ren[s], rdata[s], exp_en[s], exp_d[s]);
            end
        end
        checks++;
        if (occupancy !== 5'd0) begin errors++; $display("FAIL ooo_occ got=%0d want=0", occupancy); end
    endtask

    task automatic test_full();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        alloc_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            alloc_dest = 4'(i);
            tick();
        end
        alloc_dest = 4'hE;
        checks++;
        if (occupancy !== 5'd16 || alloc_ready !== 1'b0 || alloc_tag !== 4'd0) begin
            errors++; $display("FAIL full_state got occ=%0d ready=%b tag=%0d want occ=16 ready=0 tag=0", occupancy, alloc_ready, alloc_tag);
        end
        cdb_set(0, 4'd0, 16'h1000);
        tick();
        cdb_idle();
        checks++;
        if (occupancy !== 5'd16 || alloc_tag !== 4'd0 || ren[0] !== 1'b0) begin
            errors++; $display("FAIL full_hold got occ=%0d tag=%0d en0=%b want occ=16 tag=0 en0=0", occupancy, alloc_tag, ren[0]);
        end
        tick();
        checks++;
        if (ren[0] !== 1'b1 || rdata[0] !== 20'h10000 || ren[1] !== 1'b0) begin
            errors++; $display("FAIL full_retire got en0=%b data0=%h en1=%b want en0=1 data0=10000 en1=0", ren[0], rdata[0], ren[1]);
        end
        checks++;
        if (occupancy !== 5'd15 || alloc_ready !== 1'b1 || alloc_tag !== 4'd0) begin
            errors++; $display("FAIL full_free got occ=%0d ready=%b tag=%0d want occ=15 ready=1 tag=0", occupancy, alloc_ready, alloc_tag);
        end
        tick();
        alloc_valid = 1'b0;
        checks++;
        if (occupancy !== 5'd16 || alloc_tag !== 4'd1 || alloc_ready !== 1'b0) begin
            errors++; $display("FAIL full_refill got occ=%0d tag=%0d ready=%b want occ=16 tag=1 ready=0", occupancy, alloc_tag, alloc_ready);
        end
    endtask

    task automatic test_wrap_retire();
        logic        exp_en [3];
        logic [19:0] exp_d  [3];
        for (int t = 1; t <= 13; t += 2) begin
            cdb_set(0, 4'(t), 16'h2000 + 16'(t));
            if (t + 1 <= 13) cdb_set(1, 4'(t + 1), 16'h2000 + 16'(t + 1));
            else cv[1] = 1'b0;
            tick();
        end
        cdb_idle();
        repeat (8) tick();
        checks++;
        if (occupancy !== 5'd3) begin errors++; $display("FAIL wrap_drain got occ=%0d want=3", occupancy); end
        cdb_set(0, 4'd0, 16'h0A0A);
        tick();
        cdb_idle();
        checks++;
        if (ren[0] !== 1'b0) begin errors++; $display("FAIL wrap_wait1 got en0=%b want 0", ren[0]); end
        cdb_set(0, 4'd14, 16'h0E0E);
        cdb_set(1, 4'd15, 16'h0F0F);
        tick();
        cdb_idle();
        checks++;
        if (ren[0] !== 1'b0) begin errors++; $display("FAIL wrap_wait2 got en0=%b want 0", ren[0]); end
        tick();
        exp_en = '{1'b1, 1'b1, 1'b1};
        exp_d  = '{20'h0E0EE, 20'h0F0FF, 20'h0A0AE};
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (ren[s] !== exp_en[s] || rdata[s] !== exp_d[s]) begin
                errors++; $display("FAIL wrap_slot%0d got en=%b data=%h want en=%b data=%h", s, ren[s], rdata[s], exp_en[s], exp_d[s]);
            end
        end
        checks++;
        if (occupancy !== 5'd0 || alloc_tag !== 4'd1) begin
            errors++; $display("FAIL wrap_ptrs got occ=%0d tag=%0d want occ=0 tag=1", occupancy, alloc_tag);
        end
    endtask

    task automatic test_cdb_filter();
        logic        exp_en [3];
        logic [19:0] exp_d  [3];
        alloc_n(2, 4'd7);
        cdb_set(0, 4'd3, 16'hDEAD);
        cdb_set(1, 4'd2, 16'h0222);
        tick();
        cdb_idle();
        checks++;
        if (ren[0] !== 1'b0) begin errors++; $display("FAIL filter_none1 got en0=%b want 0", ren[0]); end
        cdb_set(0, 4'd2, 16'hBAD0);
        cdb_set(1, 4'd3, 16'hBAD1);
        tick();
        cdb_idle();
        checks++;
        if (ren[0] !== 1'b0 || occupancy !== 5'd2) begin
            errors++; $display("FAIL filter_none2 got en0=%b occ=%0d want en0=0 occ=2", ren[0], occupancy);
        end
        cdb_set(0, 4'd1, 16'h0111);
        tick();
        cdb_idle();
        tick();
        exp_en = '{1'b1, 1'b1, 1'b0};
        exp_d  = '{20'h01117, 20'h02228, 20'h0};
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (ren[s] !== exp_en[s] || rdata[s] !== exp_d[s]) begin
                errors++; $display("FAIL filter_slot%0d got en=%b data=%h want en=%b data=%h", s, ren[s], rdata[s], exp_en[s], exp_d[s]);
            end
        end
        alloc_n(1, 4'd9);
        tick();
        tick();
        checks++;
        if (ren[0] !== 1'b0 || occupancy !== 5'd1) begin
            errors++; $display("FAIL filter_stale got en0=%b occ=%0d want en0=0 occ=1", ren[0], occupancy);
        end
        cdb_set(0, 4'd3, 16'h1111);
        cdb_set(1, 4'd3, 16'h2222);
        tick();
        cdb_idle();
        tick();
        checks++;
        if (ren[0] !== 1'b1 || rdata[0] !== 20'h22229 || ren[1] !== 1'b0) begin
            errors++; $display("FAIL filter_port1_wins got en0=%b data0=%h en1=%b want en0=1 data0=22229 en1=0", ren[0], rdata[0], ren[1]);
        end
        checks++;
        if (occupancy !== 5'd0) begin errors++; $display("FAIL filter_occ got=%0d want=0", occupancy); end
    endtask

    task automatic test_reset_inflight();
        alloc_n(5, 4'd1);
        cdb_set(0, 4'd4, 16'h4444);
        cdb_set(1, 4'd5, 16'h5555);
        tick();
        cdb_idle();
        rst = 1'b1;
        alloc_valid = 1'b1;
        cdb_set(0, 4'd6, 16'h6666);
        tick();
        rst = 1'b0;
        alloc_valid = 1'b0;
        cdb_idle();
        checks++;
        if (occupancy !== 5'd0 || alloc_tag !== 4'd0 || alloc_ready !== 1'b1) begin
            errors++; $display("FAIL rst_inflight got occ=%0d tag=%0d ready=%b want occ=0 tag=0 ready=1", occupancy, alloc_tag, alloc_ready);
        end
        checks++;
        if (ren[0] !== 1'b0 || ren[1] !== 1'b0 || ren[2] !== 1'b0) begin
            errors++; $display("FAIL rst_inflight_en got en=%b%b%b want 000", ren[0], ren[1], ren[2]);
        end
        tick();
        checks++;
        if (ren[0] !== 1'b0 || occupancy !== 5'd0) begin
            errors++; $display("FAIL rst_after got en0=%b occ=%0d want en0=0 occ=0", ren[0], occupancy);
        end
    endtask

`ifdef ROB_FLUSH_EN
    task automatic test_flush();
        alloc_n(5, 4'd1);
        cdb_set(0, 4'd0, 16'h0100);
        cdb_set(1, 4'd1, 16'h0101);
        tick();
        cdb_idle();
        flush = 1'b1;
        alloc_valid = 1'b1;
        cdb_set(0, 4'd2, 16'h0102);
        tick();
        flush = 1'b0;
        alloc_valid = 1'b0;
        cdb_idle();
        checks++;
        if (occupancy !== 5'd0 || alloc_tag !== 4'd0 || ren[0] !== 1'b0 || ren[1] !== 1'b0) begin
            errors++; $display("FAIL flush_state got occ=%0d tag=%0d en=%b%b want occ=0 tag=0 en=00", occupancy, alloc_tag, ren[0], ren[1]);
        end
        tick();
        checks++;
        if (ren[0] !== 1'b0 || occupancy !== 5'd0) begin
            errors++; $display("FAIL flush_after got en0=%b occ=%0d want en0=0 occ=0", ren[0], occupancy);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
`ifdef ROB_FLUSH_EN
        flush = 1'b0;
`endif
        alloc_valid = 1'b0;
        alloc_dest  = '0;
        cdb_idle();
        test_reset();
        test_in_order();
        test_out_of_order();
        test_full();
        test_wrap_retire();
        test_cdb_filter();
        test_reset_inflight();
`ifdef ROB_FLUSH_EN
        test_flush();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
